// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the load/store path.
//   - funct3 width/sign codes used on ls_sel
//   - bus byte-enable width
//   - LSU FSM state type
//   - helpers for access size decode and misalignment detection
package riscv_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Unsupported codes (011, 110, 111) fall through to word.
  function automatic lsu_size_t ls_size(input logic [2:0] sel);
    case (sel)
      LS_B, LS_BU: return SZ_B;
      LS_H, LS_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic ls_misaligned(input logic [2:0] sel, input logic [1:0] off);
    case (ls_size(sel))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic between the core and the word bus.
// Ports:
//   st_sel, st_off, st_data -> be, lanes : byte enables and store data
//                                           replicated across all lanes
//   ld_sel, ld_off, ld_word -> ld_data   : load lane extraction with sign
//                                           (B/H) or zero (BU/HU) extension
// The store and load sides take separate select/offset inputs so the load
// side can use values captured at the start of the access.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      st_sel,
  input  logic [1:0]      st_off,
  input  logic [31:0]     st_data,
  output logic [BE_W-1:0] be,
  output logic [31:0]     lanes,
  input  logic [2:0]      ld_sel,
  input  logic [1:0]      ld_off,
  input  logic [31:0]     ld_word,
  output logic [31:0]     ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    lanes = st_data;
    case (ls_size(st_sel))
      SZ_B: begin
        be    = 4'b0001 << st_off;
        lanes = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << st_off;
        lanes = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        lanes = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_word[7:0];
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    // Halfwords are aligned here, so only off[1] picks the lane.
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    ld_data = ld_word;
    case (ld_sel)
      LS_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LS_BU:   ld_data = {24'd0, ld_byte};
      LS_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LS_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: bridges core load/store requests onto a valid/ready word bus.
// Ports:
//   clk, rst          clock, async active-high reset
//   req, we, ls_sel   core request, store flag, funct3 width/sign code
//   addr, wdata       byte address, store data
//   rdata             formatted load result (valid in DONE, held until next capture)
//   stall             freezes PC / regfile write while an aligned access is pending
//   misalign, timeout one-cycle event flags
//   bus_*             word bus master side
// Optional: define LSU_TIMEOUT_EN to enable a watchdog that aborts an access
// after TIMEOUT cycles in ACCESS without bus_ready.
//
// state  | meaning
// IDLE   | waiting for req; aligned req launches the bus access
// ACCESS | bus_valid high, bus fields held until bus_ready (or watchdog expiry)
// DONE   | rdata valid, stall released; back to IDLE next cycle
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      ls_sel,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            stall,
  output logic            misalign,
  output logic            timeout,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [31:0]     bus_wdata,
  input  logic            bus_ready,
  input  logic [31:0]     bus_rdata
);

  lsu_state_t state, state_nx;

  logic            misaligned;
  logic            access_start;
  logic            expired;
  logic [2:0]      ld_sel_q;
  logic [1:0]      ld_off_q;
  logic [BE_W-1:0] be_c;
  logic [31:0]     lanes_c;
  logic [31:0]     ld_data_c;

  assign misaligned   = ls_misaligned(ls_sel, addr[1:0]);
  assign stall        = req && (state != DONE) && !misaligned;
  assign access_start = (state == IDLE) && req && !misaligned;

  lsu_align u_align (
    .st_sel  (ls_sel),
    .st_off  (addr[1:0]),
    .st_data (wdata),
    .be      (be_c),
    .lanes   (lanes_c),
    .ld_sel  (ld_sel_q),
    .ld_off  (ld_off_q),
    .ld_word (bus_rdata),
    .ld_data (ld_data_c)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Down-counter loaded with TIMEOUT-1 on launch; reaching zero in ACCESS
  // without bus_ready means TIMEOUT access cycles have elapsed.
  logic [WDOG_W-1:0] wdog;

  assign expired = (state == ACCESS) && !bus_ready && (wdog == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expired;
      if (access_start) begin
        wdog <= WDOG_W'(TIMEOUT - 1);
      end else if ((state == ACCESS) && (wdog != '0)) begin
        wdog <= wdog - 1'b1;
      end
    end
  end
`else
  assign expired = 1'b0;
  // Without the watchdog TIMEOUT has no effect; it is folded into a constant 0.
  assign timeout = 1'b0 & (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access_start) state_nx = ACCESS;
      ACCESS:  if (bus_ready || expired) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      misalign  <= 1'b0;
      ld_sel_q  <= LS_W;
      ld_off_q  <= 2'b00;
    end else begin
      misalign <= (state == IDLE) && req && misaligned;
      case (state)
        IDLE: begin
          if (access_start) begin
            bus_valid <= 1'b1;
            bus_we    <= we;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= lanes_c;
            ld_sel_q  <= ls_sel;
            ld_off_q  <= addr[1:0];
          end else if (req && misaligned) begin
            rdata <= '0;
          end
        end
        ACCESS: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) rdata <= ld_data_c;
          end else if (expired) begin
            bus_valid <= 1'b0;
            rdata     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req, we, bus_ready;
  logic [2:0]  ls_sel;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misalign, timeout, bus_valid, bus_we;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .ls_sel    (ls_sel),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .timeout   (timeout),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_bus(input string tag);
    bus_exp_t e;
    chk({tag, ".bus_q_nonempty"}, (bus_q.size() != 0), 1);
    if (bus_q.size() != 0) begin
      e = bus_q.pop_front();
      chk({tag, ".bus_we"},    bus_we,    e.we);
      chk({tag, ".bus_addr"},  bus_addr,  e.addr);
      chk({tag, ".bus_be"},    bus_be,    e.be);
      chk({tag, ".bus_wdata"}, bus_wdata, e.wdata);
    end
  endtask

  // One core access. waits = ACCESS cycles with bus_ready low before it rises.
  task automatic run(input string tag, input logic w, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] br,
                     input int waits, input bit mis, input logic [31:0] exp_rd,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input int exp_stall, input bit exp_to);
    bus_exp_t    e;
    bit          seen = 0;
    bit          done = 0;
    int          stall_cnt = 0;
    int          acc = 0;
    logic [31:0] exp_r;
    if (!mis) begin
      e.we = w; e.addr = {a[31:2], 2'b00}; e.be = exp_be; e.wdata = exp_wd;
      bus_q.push_back(e);
    end
    rd_q.push_back(exp_rd);
    @(negedge clk);
    req = 1'b1; we = w; ls_sel = sel; addr = a; wdata = wd; bus_rdata = br; bus_ready = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (bus_valid) begin
        acc++;
        if (!seen) begin
          seen = 1;
          compare_bus(tag);
        end
        bus_ready = (acc > waits);
      end else begin
        bus_ready = 1'b0;
        if (!stall) done = 1;
      end
      if (!done) @(negedge clk);
    end
    chk({tag, ".completed"}, done, 1);
    chk({tag, ".stall_cycles"}, stall_cnt, exp_stall);
    chk({tag, ".bus_used"}, seen, !mis);
    chk({tag, ".valid_dropped"}, bus_valid, 0);
    bus_ready = 1'b0;
    exp_r = rd_q.pop_front();
    if (!mis) begin
      req = 1'b0;
      chk({tag, ".rdata"}, rdata, exp_r);
      chk({tag, ".timeout"}, timeout, exp_to);
      chk({tag, ".no_misalign"}, misalign, 0);
    end else begin
      @(negedge clk);
      req = 1'b0;
      #1;
      chk({tag, ".misalign_pulse"}, misalign, 1);
      chk({tag, ".rdata"}, rdata, exp_r);
      chk({tag, ".no_valid"}, bus_valid, 0);
      @(negedge clk);
      #1;
      chk({tag, ".misalign_clear"}, misalign, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    bus_exp_t e;
    rst = 1'b1; req = 1'b0; we = 1'b0; ls_sel = 3'b000; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.bus_valid", bus_valid, 0);
    chk("rst.bus_we",    bus_we,    0);
    chk("rst.bus_addr",  bus_addr,  0);
    chk("rst.bus_be",    bus_be,    0);
    chk("rst.bus_wdata", bus_wdata, 0);
    chk("rst.rdata",     rdata,     0);
    chk("rst.misalign",  misalign,  0);
    chk("rst.timeout",   timeout,   0);
    chk("rst.stall",     stall,     0);
    rst = 1'b0;

    //  tag      we   sel     addr          wdata         bus_rdata     wt mis exp_rdata     be       bus_wdata     stall to
    run("lw",    0, LS_W,   32'h100, 32'h0,        32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 4'b1111, 32'h0,        5, 0);
    run("lb",    0, LS_B,   32'h103, 32'h0,        32'h80FFFFFF, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        3, 0);
    run("lbu",   0, LS_BU,  32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 32'h00000080, 4'b1000, 32'h0,        2, 0);
    run("sh",    1, LS_H,   32'h202, 32'h0000ABCD, 32'h0,        2, 0, 32'h00000080, 4'b1100, 32'hABCDABCD, 4, 0);
    run("lh",    0, LS_H,   32'h102, 32'h0,        32'h80011234, 1, 0, 32'hFFFF8001, 4'b1100, 32'h0,        3, 0);
    run("lhu",   0, LS_HU,  32'h102, 32'h0,        32'h80011234, 0, 0, 32'h00008001, 4'b1100, 32'h0,        2, 0);
    run("lh0",   0, LS_H,   32'h100, 32'h0,        32'h80017FFE, 0, 0, 32'h00007FFE, 4'b0011, 32'h0,        2, 0);
    run("sb",    1, LS_B,   32'h101, 32'h000000A5, 32'h0,        0, 0, 32'h00007FFE, 4'b0010, 32'hA5A5A5A5, 2, 0);
    run("sel011",0, 3'b011, 32'h104, 32'h0,        32'h12345678, 0, 0, 32'h12345678, 4'b1111, 32'h0,        2, 0);
    run("sw",    1, LS_W,   32'h200, 32'hCAFEF00D, 32'h0,        1, 0, 32'h12345678, 4'b1111, 32'hCAFEF00D, 3, 0);
    run("lw_mis",0, LS_W,   32'h101, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 0);
    run("sw_mis",1, LS_W,   32'h102, 32'h11111111, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 0);
    run("lh_mis",0, LS_H,   32'h103, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 0);
    run("lw2",   0, LS_W,   32'h104, 32'h0,        32'h55AA55AA, 0, 0, 32'h55AA55AA, 4'b1111, 32'h0,        2, 0);

    // bus_ready while idle must not start or complete anything
    bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ready.bus_valid", bus_valid, 0);
      chk("idle_ready.rdata", rdata, 32'h55AA55AA);
    end
    bus_ready = 1'b0;

    // reset in the middle of an access
    e.we = 1'b0; e.addr = 32'h300; e.be = 4'b1111; e.wdata = 32'h0;
    bus_q.push_back(e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; ls_sel = LS_W; addr = 32'h300; bus_rdata = 32'h99999999;
    @(negedge clk);
    #1;
    chk("rst_mid.valid_before", bus_valid, 1);
    compare_bus("rst_mid");
    rst = 1'b1;
    #1;
    chk("rst_mid.valid_dropped", bus_valid, 0);
    chk("rst_mid.rdata", rdata, 0);
    chk("rst_mid.bus_addr", bus_addr, 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rst_mid.no_retry", bus_valid, 0);
      chk("rst_mid.stall", stall, 0);
    end

`ifdef LSU_TIMEOUT_EN
    run("pre_to",0, LS_W,   32'h108, 32'h0,        32'h11111111, 0, 0, 32'h11111111, 4'b1111, 32'h0,        2, 0);
    run("to",    0, LS_W,   32'h10C, 32'h0,        32'h22222222, 1000, 0, 32'h0,     4'b1111, 32'h0,        5, 1);
    #1;
    chk("to.pulse_clear", timeout, 0);
`endif

    chk("end.bus_q_empty", bus_q.size(), 0);
    chk("end.rd_q_empty", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
